// File: rtl/ram_2w_write_dispatch.sv
// Write-side front end for the 8R/2W LVT RAM: two buffered request streams,
// registered RAM write ports, and same-address serialisation (stream 1 first).
module ram_2w_write_dispatch #(
    parameter int BLOCKSIZE = 12,
    parameter int DATA_W    = 32,
    parameter int FIFO_AW   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_1,
    output logic                 in_ready_1,
    input  logic [BLOCKSIZE:0]   in_addr_1,
    input  logic [DATA_W-1:0]    in_din_1,
    input  logic                 in_valid_2,
    output logic                 in_ready_2,
    input  logic [BLOCKSIZE:0]   in_addr_2,
    input  logic [DATA_W-1:0]    in_din_2,
    input  logic                 ram_hold,
    output logic                 w_enb_1,
    output logic [BLOCKSIZE:0]   w_addr_1,
    output logic [DATA_W-1:0]    w_din_1,
    output logic                 w_enb_2,
    output logic [BLOCKSIZE:0]   w_addr_2,
    output logic [DATA_W-1:0]    w_din_2,
    output logic                 idle,
    output logic [CNT_W-1:0]     coll_cnt
);

    localparam int AW    = BLOCKSIZE + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [1:0]             vld_s;
    logic [1:0]             ready_s;
    logic [1:0]             push_s;
    logic [1:0]             head_v_s;
    logic [1:0]             pop_s;
    logic [1:0]             wen_s;
    logic                   coll_s;
    logic [1:0][AW-1:0]     in_addr_s;
    logic [1:0][DATA_W-1:0] in_din_s;
    logic [1:0][AW-1:0]     head_addr_s;
    logic [1:0][DATA_W-1:0] head_din_s;
    logic [1:0][AW-1:0]     waddr_s;
    logic [1:0][DATA_W-1:0] wdin_s;
    logic [CNT_W-1:0]       coll_q;
    logic [CNT_W-1:0]       coll_d;

    assign vld_s     = {in_valid_2, in_valid_1};
    assign in_addr_s = {in_addr_2, in_addr_1};
    assign in_din_s  = {in_din_2, in_din_1};

    // Index 0 is stream 1 / RAM port 1, index 1 is stream 2 / RAM port 2.
    for (genvar k = 0; k < 2; k++) begin : g_stream
        logic [AW-1:0]     fifo_addr_q [DEPTH];
        logic [DATA_W-1:0] fifo_din_q  [DEPTH];
        logic [FIFO_AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
        logic [FIFO_AW:0]   cnt_q, cnt_d;
        logic               wen_q;
        logic [AW-1:0]      waddr_q, waddr_d;
        logic [DATA_W-1:0]  wdin_q, wdin_d;

        assign ready_s[k]     = (cnt_q < FULL_CNT);
        assign push_s[k]      = vld_s[k] & ready_s[k];
        assign head_v_s[k]    = (cnt_q != '0);
        assign head_addr_s[k] = fifo_addr_q[rptr_q];
        assign head_din_s[k]  = fifo_din_q[rptr_q];
        assign wen_s[k]       = wen_q;
        assign waddr_s[k]     = waddr_q;
        assign wdin_s[k]      = wdin_q;

        // Pointer, occupancy and output-port next state.
        always_comb begin
            wptr_d  = push_s[k] ? wptr_q + FIFO_AW'(1) : wptr_q;
            rptr_d  = pop_s[k]  ? rptr_q + FIFO_AW'(1) : rptr_q;
            case ({push_s[k], pop_s[k]})
                2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
            waddr_d = pop_s[k] ? head_addr_s[k] : waddr_q;
            wdin_d  = pop_s[k] ? head_din_s[k]  : wdin_q;
        end

        // Control state and registered write port.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                cnt_q   <= '0;
                wen_q   <= 1'b0;
                waddr_q <= '0;
                wdin_q  <= '0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                cnt_q   <= cnt_d;
                wen_q   <= pop_s[k];
                waddr_q <= waddr_d;
                wdin_q  <= wdin_d;
            end
        end

        // Payload storage needs no reset; occupancy alone marks entries valid.
        always_ff @(posedge clk) begin
            if (push_s[k]) begin
                fifo_addr_q[wptr_q] <= in_addr_s[k];
                fifo_din_q[wptr_q]  <= in_din_s[k];
            end
        end
    end

    // Issue decision: a same-address pair sends stream 1 now and holds stream 2.
    always_comb begin
        pop_s  = 2'b00;
        coll_s = 1'b0;
        if (ram_hold) begin
            pop_s = 2'b00;
        end else begin
            case (head_v_s)
                2'b01:   pop_s = 2'b01;
                2'b10:   pop_s = 2'b10;
                2'b11: begin
                    if (head_addr_s[0] == head_addr_s[1]) begin
                        pop_s  = 2'b01;
                        coll_s = 1'b1;
                    end else begin
                        pop_s  = 2'b11;
                    end
                end
                default: pop_s = 2'b00;
            endcase
        end
        coll_d = (coll_s && (coll_q != {CNT_W{1'b1}})) ? coll_q + CNT_W'(1) : coll_q;
    end

    // Saturating collision counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= '0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign in_ready_1 = ready_s[0];
    assign in_ready_2 = ready_s[1];
    assign w_enb_1    = wen_s[0];
    assign w_addr_1   = waddr_s[0];
    assign w_din_1    = wdin_s[0];
    assign w_enb_2    = wen_s[1];
    assign w_addr_2   = waddr_s[1];
    assign w_din_2    = wdin_s[1];
    assign coll_cnt   = coll_q;
    assign idle       = ~(|head_v_s) & ~(|wen_s);

endmodule

// File: doc/ram_2w_write_dispatch.md
Name: ram_2w_write_dispatch

Overview:
Write-side front end for the 8-read/2-write LVT RAM. It accepts two independent write-request streams over valid/ready handshakes and buffers each stream in its own FIFO. It drives the RAM's two write ports from registered outputs. When both FIFO heads target the same address in the same cycle, it serialises them so the LVT always records a deterministic winner.

Parameters:
BLOCKSIZE, 12, address MSB index; addresses are BLOCKSIZE+1 bits (matches RAM)
DATA_W, 32, write data width
FIFO_AW, 2, log2 of per-stream FIFO depth (depth 4)
CNT_W, 16, width of collision counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid_1  in  1  stream-1 request valid
in_ready_1  out  1  stream-1 FIFO can accept
in_addr_1  in  BLOCKSIZE+1  stream-1 write address
in_din_1  in  DATA_W  stream-1 write data
in_valid_2  in  1  stream-2 request valid
in_ready_2  out  1  stream-2 FIFO can accept
in_addr_2  in  BLOCKSIZE+1  stream-2 write address
in_din_2  in  DATA_W  stream-2 write data
ram_hold  in  1  downstream stall; no writes are issued while high
w_enb_1  out  1  RAM write port 1 enable (registered)
w_addr_1  out  BLOCKSIZE+1  RAM write port 1 address (registered)
w_din_1  out  DATA_W  RAM write port 1 data (registered)
w_enb_2  out  1  RAM write port 2 enable (registered)
w_addr_2  out  BLOCKSIZE+1  RAM write port 2 address (registered)
w_din_2  out  DATA_W  RAM write port 2 data (registered)
idle  out  1  both FIFOs empty and both w_enb low
coll_cnt  out  CNT_W  count of same-address collisions deferred

Behaviour:
- Reset (rst=1 at a rising edge): both FIFOs empty, pointers 0; w_enb_1/2=0; w_addr_*/w_din_*=0; coll_cnt=0; in_ready_*=1 from the first cycle after reset; idle=1. Reset mid-operation discards all buffered requests. No write is issued in the cycle after reset.
- Accept: a request transfers when in_valid_k && in_ready_k at a rising edge.
- in_ready_k = (count_k < 2^FIFO_AW). It is purely a function of registered count and does not depend on in_valid or pop.
- Push and pop in the same cycle are allowed in any non-full state. The count is unchanged.
- Issue decision is combinational from the FIFO heads (h1, h2 = head valid):
  - ram_hold=1: no pop; next w_enb_1/2=0.
  - Else, with exactly one head valid: pop that head; load its port; the other enable is 0.
  - Else, with both heads valid and different addresses: pop both; both enables are 1.
  - Else, with both heads valid and equal addresses (collision): pop stream 1 only; next w_enb_1=1, w_enb_2=0; stream-2 head is held. coll_cnt increments, saturating at all-ones. The next cycle's decision re-evaluates against the new stream-1 head.
- Stream k always drives RAM port k, so the LVT bank mapping is fixed.
- Latency: a request accepted at edge N into an empty FIFO appears on w_* after edge N+1. Its RAM write lands at the RAM's write edge following that.
- Ordering:
  - Within a stream: strict FIFO order.
  - Across streams, same address, same cycle: stream 1 is written first and stream 2 last, so stream 2's data is the final value.
  - Across streams, different cycles: issue order.
- When w_enb_k=0, w_addr_k/w_din_k hold their previous values.
- Throughput: 2 writes/cycle when there is no hold and no collision.
- idle = !h1 && !h2 && !w_enb_1 && !w_enb_2.

Test Plan:
- Reset then single write: stream 1 sends addr 0x005/data 0xDEADBEEF at edge 1. After edge 2, w_enb_1=1, w_addr_1=0x005, w_din_1=0xDEADBEEF, w_enb_2=0. After edge 3, idle=1.
- Dual write, distinct addresses: stream 1 sends 0x010/0x11111111 and stream 2 sends 0x020/0x22222222 in the same cycle. Both ports are enabled in the following cycle; coll_cnt=0.
- Collision: both streams send addr 0x0AA, data 0xA1 (stream 1) and 0xB2 (stream 2). Cycle +1: only port 1 (0xA1). Cycle +2: only port 2 (0xB2). coll_cnt=1. A subsequent RAM read of 0x0AA returns 0xB2.
- Full/backpressure: hold ram_hold=1 and push 5 requests on stream 1. in_ready_1 goes low after the 4th accept and the 5th is not accepted. Release hold: 4 writes drain in order on consecutive cycles, and in_ready_1 returns high the cycle after the first pop.
- Reset mid-operation: with 3 entries in each FIFO and w_enb high, assert rst for one cycle. Next cycle: w_enb_1/2=0, coll_cnt=0, in_ready_*=1, idle=1, and no stale write is issued afterwards.
- coll_cnt saturation with CNT_W=2: force 5 consecutive collisions; coll_cnt stops at 3.
